// File: rtl/operand_match_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : operand_match_scheduler_if
// Description : Handshake bundle between a bitmask-pair producer, the
//               operand-match scheduler and the MAC lanes it feeds.
//               Input side : ivalid / iready / bitmaskW / bitmaskA
//               Output side: ovalid / oready / oLaneValid / oIdxW / oIdxA /
//                            olast / oConsumeW / oConsumeA
//               slave  modport : scheduler view (accepts pairs, issues beats)
//               master modport : environment view (drives pairs, sinks beats)
// Revision    : 1.0 - initial release
// ============================================================================
interface operand_match_scheduler_if #(
    parameter int BITMASK_WIDTH = 8,
    parameter int ISSUE_WIDTH   = 2
);
    localparam int c_IDX_W = $clog2(BITMASK_WIDTH);
    localparam int c_CNT_W = $clog2(BITMASK_WIDTH + 1);

    logic                           ivalid;
    logic                           iready;
    logic [BITMASK_WIDTH-1:0]       bitmaskW;
    logic [BITMASK_WIDTH-1:0]       bitmaskA;
    logic                           ovalid;
    logic                           oready;
    logic [ISSUE_WIDTH-1:0]         oLaneValid;
    logic [ISSUE_WIDTH*c_IDX_W-1:0] oIdxW;
    logic [ISSUE_WIDTH*c_IDX_W-1:0] oIdxA;
    logic                           olast;
    logic [c_CNT_W-1:0]             oConsumeW;
    logic [c_CNT_W-1:0]             oConsumeA;

    modport slave (
        input  ivalid, bitmaskW, bitmaskA, oready,
        output iready, ovalid, oLaneValid, oIdxW, oIdxA, olast,
               oConsumeW, oConsumeA
    );

    modport master (
        output ivalid, bitmaskW, bitmaskA, oready,
        input  iready, ovalid, oLaneValid, oIdxW, oIdxA, olast,
               oConsumeW, oConsumeA
    );
endinterface
`default_nettype wire

// File: rtl/operand_match_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : operand_match_scheduler
// Description : Sparse operand-matching sequencer for one PE. Accepts a
//               (bitmaskW, bitmaskA) pair, forms match = W & A and issues the
//               matched positions ISSUE_WIDTH per beat, lowest position first.
//               Each issued lane carries its offset into the compressed weight
//               and activation streams (popcount of the mask below the
//               position). The final beat of a pair reports how many
//               compressed words each stream consumes. A pair with no match
//               still produces exactly one (empty) final beat so downstream
//               stream pointers advance.
// Ports       : clock   - clock
//               resetn  - asynchronous active-low reset
//               bus     - operand_match_scheduler_if.slave
//                         (pair input handshake + issue beat output)
// Revision    : 1.0 - initial release
// ============================================================================
module operand_match_scheduler #(
    parameter int BITMASK_WIDTH = 8,
    parameter int ISSUE_WIDTH   = 2
) (
    input  wire logic                  clock,
    input  wire logic                  resetn,
    operand_match_scheduler_if.slave   bus
);

    localparam int c_IDX_W = $clog2(BITMASK_WIDTH);
    localparam int c_CNT_W = $clog2(BITMASK_WIDTH + 1);

    localparam logic [c_CNT_W-1:0] c_ISSUE_CNT = c_CNT_W'(ISSUE_WIDTH);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_ISSUE = 1'b1;

    // ------------------------------------------------------------------------
    // State and pair registers
    // ------------------------------------------------------------------------
    logic [0:0]               r_state;
    logic [0:0]               w_state_nxt;
    logic [BITMASK_WIDTH-1:0] r_w;
    logic [BITMASK_WIDTH-1:0] r_a;
    logic [BITMASK_WIDTH-1:0] r_pending;

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    // w_pre_*[p] = popcount(mask[p-1:0]); entry BITMASK_WIDTH is the total.
    logic [c_CNT_W-1:0]             w_pre_w    [BITMASK_WIDTH+1];
    logic [c_CNT_W-1:0]             w_pre_a    [BITMASK_WIDTH+1];
    // w_rank[p] = number of pending bits strictly below p (lane slot of p).
    logic [c_CNT_W-1:0]             w_rank     [BITMASK_WIDTH+1];
    logic [ISSUE_WIDTH-1:0]         w_lane_valid;
    logic [ISSUE_WIDTH*c_IDX_W-1:0] w_idx_w;
    logic [ISSUE_WIDTH*c_IDX_W-1:0] w_idx_a;
    logic [BITMASK_WIDTH-1:0]       w_issue_mask;
    logic                           w_olast;

    // FSM outputs and handshake qualifiers
    logic w_ovalid;
    logic w_iready;
    logic w_accept;
    logic w_fire;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // A retiring final beat may coincide with the next pair being accepted;
    // in that case the FSM stays in ISSUE so pairs flow without a bubble.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = c_ISSUE;
                end
            end
            c_ISSUE: begin
                if (w_fire && w_olast) begin
                    w_state_nxt = w_accept ? c_ISSUE : c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic
    // iready looks at oready combinationally so the next pair can be taken on
    // the same edge the current pair retires. It is held low during reset.
    // ------------------------------------------------------------------------
    always_comb begin
        w_ovalid = (r_state == c_ISSUE);
        w_iready = resetn &&
                   ((r_state == c_IDLE) ||
                    ((r_state == c_ISSUE) && bus.oready && w_olast));
    end

    assign w_accept = bus.ivalid && w_iready;
    assign w_fire   = w_ovalid && bus.oready;

    // ------------------------------------------------------------------------
    // Pair registers: load on accept, otherwise strip issued bits per beat.
    // On the final beat every remaining pending bit is issued, so pending
    // returns to zero when the pair retires.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_w       <= '0;
            r_a       <= '0;
            r_pending <= '0;
        end else if (w_accept) begin
            r_w       <= bus.bitmaskW;
            r_a       <= bus.bitmaskA;
            r_pending <= bus.bitmaskW & bus.bitmaskA;
        end else if (w_fire) begin
            r_pending <= r_pending & ~w_issue_mask;
        end
    end

    // ------------------------------------------------------------------------
    // Beat formation: driven from registers only, so a stalled beat is stable.
    // ------------------------------------------------------------------------
    always_comb begin
        w_pre_w[0] = '0;
        w_pre_a[0] = '0;
        w_rank[0]  = '0;
        for (int p = 0; p < BITMASK_WIDTH; p++) begin
            w_pre_w[p+1] = w_pre_w[p] + {{(c_CNT_W-1){1'b0}}, r_w[p]};
            w_pre_a[p+1] = w_pre_a[p] + {{(c_CNT_W-1){1'b0}}, r_a[p]};
            w_rank[p+1]  = w_rank[p]  + {{(c_CNT_W-1){1'b0}}, r_pending[p]};
        end

        w_issue_mask = '0;
        for (int p = 0; p < BITMASK_WIDTH; p++) begin
            if (r_pending[p] && (w_rank[p] < c_ISSUE_CNT)) begin
                w_issue_mask[p] = 1'b1;
            end
        end

        // Lane k takes the pending bit whose rank equals k; at most one
        // position can match a given rank, so the ORed assignments never clash.
        w_lane_valid = '0;
        w_idx_w      = '0;
        w_idx_a      = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            for (int p = 0; p < BITMASK_WIDTH; p++) begin
                if (r_pending[p] && (w_rank[p] == c_CNT_W'(k))) begin
                    w_lane_valid[k]                 = 1'b1;
                    w_idx_w[k*c_IDX_W +: c_IDX_W]   = c_IDX_W'(w_pre_w[p]);
                    w_idx_a[k*c_IDX_W +: c_IDX_W]   = c_IDX_W'(w_pre_a[p]);
                end
            end
        end

        // A zero-match pair has popcount 0 and therefore is its own last beat.
        w_olast = (w_rank[BITMASK_WIDTH] <= c_ISSUE_CNT);
    end

    // ------------------------------------------------------------------------
    // Output drive: everything is gated by ovalid so idle outputs read zero.
    // ------------------------------------------------------------------------
    assign bus.iready     = w_iready;
    assign bus.ovalid     = w_ovalid;
    assign bus.oLaneValid = w_ovalid ? w_lane_valid : '0;
    assign bus.oIdxW      = w_ovalid ? w_idx_w : '0;
    assign bus.oIdxA      = w_ovalid ? w_idx_a : '0;
    assign bus.olast      = w_ovalid && w_olast;
    assign bus.oConsumeW  = (w_ovalid && w_olast) ? w_pre_w[BITMASK_WIDTH] : '0;
    assign bus.oConsumeA  = (w_ovalid && w_olast) ? w_pre_a[BITMASK_WIDTH] : '0;

endmodule
`default_nettype wire

// File: tb/tb_operand_match_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_match_scheduler
// Description : Directed scoreboard bench for operand_match_scheduler.
//               Stimulus pushes hand-computed expected beats into a queue; a
//               monitor pops and compares on every accepted output beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_match_scheduler;

    localparam int c_BW = 8;
    localparam int c_IW = 2;

    logic clock = 1'b0;
    logic resetn;

    always #5 clock = ~clock;

    operand_match_scheduler_if #(.BITMASK_WIDTH(c_BW), .ISSUE_WIDTH(c_IW)) bus ();

    operand_match_scheduler #(
        .BITMASK_WIDTH (c_BW),
        .ISSUE_WIDTH   (c_IW)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct packed {
        logic [1:0] lanes;
        logic [5:0] iw;     // {lane1, lane0}
        logic [5:0] ia;
        logic       last;
        logic [3:0] cw;
        logic [3:0] ca;
    } beat_t;

    beat_t exp_q[$];
    int    checks     = 0;
    int    failures   = 0;
    int    beats_seen = 0;

    function automatic beat_t mk(int lanes, int w0, int a0, int w1, int a1,
                                 int last, int cw, int ca);
        beat_t b;
        b.lanes = 2'(lanes);
        b.iw    = {3'(w1), 3'(w0)};
        b.ia    = {3'(a1), 3'(a0)};
        b.last  = 1'(last);
        b.cw    = 4'(cw);
        b.ca    = 4'(ca);
        return b;
    endfunction

    function automatic beat_t cur();
        beat_t b;
        b = {bus.oLaneValid, bus.oIdxW, bus.oIdxA, bus.olast,
             bus.oConsumeW, bus.oConsumeA};
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: compare every accepted beat against the scoreboard head.
    always @(negedge clock) begin
        beat_t e;
        if (resetn === 1'b1 && bus.ovalid === 1'b1 && bus.oready === 1'b1) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual=%h expected=none", cur());
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("beat%0d", beats_seen), 32'(cur()), 32'(e));
            end
        end
    end

    // Present a pair until accepted; called and returns at posedge+1.
    task automatic send(input logic [7:0] w, input logic [7:0] a,
                        output int waited);
        logic acc;
        acc           = 1'b0;
        waited        = 0;
        bus.ivalid    = 1'b1;
        bus.bitmaskW  = w;
        bus.bitmaskA  = a;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            acc = bus.iready;
            @(posedge clock);
            #1;
            if (acc) break;
            waited++;
        end
        bus.ivalid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=not_accepted expected=accepted");
        end
    endtask

    // Wait for the scoreboard to empty and the retiring edge to pass.
    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=%0d expected=0 beats left", name,
                     exp_q.size());
            exp_q.delete();
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        int wt;
        int base;
        logic [7:0] t5_w [6];
        logic [7:0] t5_a [6];

        resetn       = 1'b0;
        bus.ivalid   = 1'b0;
        bus.bitmaskW = '0;
        bus.bitmaskA = '0;
        bus.oready   = 1'b1;

        // Reset state
        @(negedge clock);
        chk("rst_ovalid", 32'(bus.ovalid), 32'd0);
        chk("rst_iready", 32'(bus.iready), 32'd0);
        chk("rst_beat",   32'(cur()),      32'd0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        @(negedge clock);
        chk("post_rst_iready", 32'(bus.iready), 32'd1);
        chk("post_rst_ovalid", 32'(bus.ovalid), 32'd0);
        @(posedge clock);
        #1;

        // T1: match bits 1,4,7 -> two beats
        exp_q.push_back(mk(3, 0, 1, 2, 2, 0, 0, 0));
        exp_q.push_back(mk(1, 4, 4, 0, 0, 1, 5, 5));
        send(8'b1011_0110, 8'b1101_0011, wt);
        drain("t1");

        // T2: zero match -> one empty final beat
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 4, 4));
        send(8'hF0, 8'h0F, wt);
        drain("t2");
        @(negedge clock);
        chk("t2_iready_idle", 32'(bus.iready), 32'd1);
        chk("t2_ovalid_idle", 32'(bus.ovalid), 32'd0);
        @(posedge clock);
        #1;

        // T3: full match -> four beats
        exp_q.push_back(mk(3, 0, 0, 1, 1, 0, 0, 0));
        exp_q.push_back(mk(3, 2, 2, 3, 3, 0, 0, 0));
        exp_q.push_back(mk(3, 4, 4, 5, 5, 0, 0, 0));
        exp_q.push_back(mk(3, 6, 6, 7, 7, 1, 8, 8));
        send(8'hFF, 8'hFF, wt);
        drain("t3");

        // T4: T1 with beat1 stalled three cycles; junk ivalid must be ignored
        bus.oready = 1'b0;
        exp_q.push_back(mk(3, 0, 1, 2, 2, 0, 0, 0));
        exp_q.push_back(mk(1, 4, 4, 0, 0, 1, 5, 5));
        send(8'b1011_0110, 8'b1101_0011, wt);
        for (int i = 0; i < 3; i++) begin
            bus.ivalid   = 1'b1;
            bus.bitmaskW = 8'hFF;
            bus.bitmaskA = 8'hFF;
            @(negedge clock);
            chk($sformatf("t4_hold%0d", i), 32'(cur()),
                32'(mk(3, 0, 1, 2, 2, 0, 0, 0)));
            chk($sformatf("t4_ovalid%0d", i), 32'(bus.ovalid), 32'd1);
            chk($sformatf("t4_iready%0d", i), 32'(bus.iready), 32'd0);
            @(posedge clock);
            #1;
        end
        bus.ivalid = 1'b0;
        bus.oready = 1'b1;
        drain("t4");

        // T5: six single-beat pairs back to back
        t5_w = '{8'h01, 8'h03, 8'hFF, 8'h0C, 8'h00, 8'hA5};
        t5_a = '{8'h01, 8'h02, 8'h80, 8'h0C, 8'hFF, 8'h24};
        exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1));
        exp_q.push_back(mk(1, 1, 0, 0, 0, 1, 2, 1));
        exp_q.push_back(mk(1, 7, 0, 0, 0, 1, 8, 1));
        exp_q.push_back(mk(3, 0, 0, 1, 1, 1, 2, 2));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8));
        exp_q.push_back(mk(3, 1, 0, 2, 1, 1, 4, 2));
        base = beats_seen;
        for (int i = 0; i < 6; i++) begin
            send(t5_w[i], t5_a[i], wt);
            chk($sformatf("t5_nobubble%0d", i), 32'(wt), 32'd0);
        end
        drain("t5");
        chk("t5_beat_count", 32'(beats_seen - base), 32'd6);

        // T6: reset during beat1 of T3, then a fresh pair
        bus.oready = 1'b0;
        send(8'hFF, 8'hFF, wt);
        #2;
        chk("t6_pre_ovalid", 32'(bus.ovalid), 32'd1);
        resetn = 1'b0;
        #1;
        chk("t6_rst_ovalid", 32'(bus.ovalid), 32'd0);
        chk("t6_rst_beat",   32'(cur()),      32'd0);
        chk("t6_rst_iready", 32'(bus.iready), 32'd0);
        @(posedge clock);
        #1;
        resetn     = 1'b1;
        bus.oready = 1'b1;
        @(negedge clock);
        chk("t6_idle_iready", 32'(bus.iready), 32'd1);
        chk("t6_idle_ovalid", 32'(bus.ovalid), 32'd0);
        @(posedge clock);
        #1;
        exp_q.push_back(mk(3, 0, 1, 2, 2, 0, 0, 0));
        exp_q.push_back(mk(1, 4, 4, 0, 0, 1, 5, 5));
        send(8'b1011_0110, 8'b1101_0011, wt);
        drain("t6");

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
